// File: rtl/nsb_keycode_fifo.sv
// Keycode FIFO between the NextSoundBox keyboard interface and the sys PIO; optional KEYCODE_DUP_FILTER_EN drops repeated keycodes.
// Latency: a push/pop at cycle N shows in head_out/count/empty from cycle N+1; overflow is sticky.
// Backpressure: none upstream; a push into a full FIFO is dropped and flagged, a pop of an empty FIFO is ignored.
module nsb_keycode_fifo #(
    parameter int DW         = 16,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk27,
    input  logic                  po_reset_n,
    input  logic [DW-1:0]         keycode_in,
    input  logic                  keycode_vld,
    input  logic                  pop_tgl,
    input  logic                  ovf_clr,
    output logic [DW-1:0]         head_out,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty,
    output logic                  overflow
);

    localparam int                DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = DEPTH[DEPTH_LOG2:0];

    // Register-based storage, small enough that a RAM macro would not pay off.
    logic [DW-1:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic                    kv_prev;
    logic                    pop_tgl_prev;

    logic                    push_evt;
    logic                    pop_evt;
    logic                    full;
    logic                    do_push;
    logic                    do_pop;
    logic                    ovf_set;
    logic                    dup_hit;
    logic [DEPTH_LOG2-1:0]   rd_next;
    logic [DEPTH_LOG2:0]     cnt_next;
    logic [DW-1:0]           head_next;

`ifdef KEYCODE_DUP_FILTER_EN
    logic [DW-1:0]           last_accepted;

    // A repeat of the last stored keycode is swallowed; zero is always let through.
    assign dup_hit = (keycode_in == last_accepted) && (keycode_in != '0);

    // Remember the most recent keycode that actually entered the FIFO.
    always_ff @(posedge clk27 or negedge po_reset_n) begin
        if (!po_reset_n) begin
            last_accepted <= '0;
        end else if (do_push) begin
            last_accepted <= keycode_in;
        end
    end
`else
    assign dup_hit = 1'b0;
`endif

    // Event detection, full/empty arbitration and next-state computation.
    always_comb begin
        push_evt = keycode_vld & ~kv_prev & ~dup_hit;
        pop_evt  = pop_tgl ^ pop_tgl_prev;
        full     = (count == FULL_CNT);
        do_pop   = pop_evt & (count != '0);
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
        do_push  = push_evt & (~full | do_pop);
        ovf_set  = push_evt & full & ~do_pop;

        rd_next  = do_pop ? rd_ptr + 1'b1 : rd_ptr;

        cnt_next = count;
        case ({do_push, do_pop})
            2'b10:   cnt_next = count + 1'b1;
            2'b01:   cnt_next = count - 1'b1;
            default: cnt_next = count;
        endcase

        // The new head may be the entry being written this very cycle, so bypass it.
        head_next = mem[rd_next];
        if (cnt_next == '0) begin
            head_next = '0;
        end else if (do_push && (rd_next == wr_ptr)) begin
            head_next = keycode_in;
        end
    end

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk27) begin
        if (do_push) begin
            mem[wr_ptr] <= keycode_in;
        end
    end

    // Pointers, counter, edge-detect history and registered status outputs.
    always_ff @(posedge clk27 or negedge po_reset_n) begin
        if (!po_reset_n) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            kv_prev      <= 1'b0;
            pop_tgl_prev <= 1'b0;
            count        <= '0;
            empty        <= 1'b1;
            head_out     <= '0;
            overflow     <= 1'b0;
        end else begin
            kv_prev      <= keycode_vld;
            pop_tgl_prev <= pop_tgl;
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr   <= rd_next;
            count    <= cnt_next;
            empty    <= (cnt_next == '0);
            head_out <= head_next;
            // Set has priority over clear so a drop is never lost.
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nsb_keycode_fifo.sv
// Scoreboard bench for nsb_keycode_fifo: stimulus queues expected state, a monitor compares on the falling edge.
// Latency checked: state is expected one clock after the stimulus edge.
// Backpressure exercised: full-FIFO drops, same-cycle push/pop, pops of an empty FIFO.
module tb_nsb_keycode_fifo;

    logic        clk27 = 1'b0;
    logic        po_reset_n;
    logic [15:0] keycode_in;
    logic        keycode_vld;
    logic        pop_tgl;
    logic        ovf_clr;
    logic [15:0] head_out;
    logic [3:0]  count;
    logic        empty;
    logic        overflow;

    typedef struct {
        string       name;
        logic [15:0] head;
        logic [3:0]  cnt;
        logic        emp;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    nsb_keycode_fifo #(.DW(16), .DEPTH_LOG2(3)) dut (
        .clk27       (clk27),
        .po_reset_n  (po_reset_n),
        .keycode_in  (keycode_in),
        .keycode_vld (keycode_vld),
        .pop_tgl     (pop_tgl),
        .ovf_clr     (ovf_clr),
        .head_out    (head_out),
        .count       (count),
        .empty       (empty),
        .overflow    (overflow)
    );

    always #5 clk27 = ~clk27;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk27);
        #1;
    endtask

    task automatic exp_state(input string nm, input logic [15:0] h, input int c, input logic o);
        exp_t e;
        e.name = nm;
        e.head = h;
        e.cnt  = c[3:0];
        e.emp  = (c == 0);
        e.ovf  = o;
        sb.push_back(e);
    endtask

    task automatic push(input logic [15:0] k);
        keycode_in  = k;
        keycode_vld = 1'b1;
        tick();
        keycode_vld = 1'b0;
        tick();
    endtask

    task automatic pop();
        pop_tgl = ~pop_tgl;
        tick();
    endtask

    // Asynchronous reset asserted between clock edges; checked before any further edge.
    task automatic mid_reset(input string nm);
        @(posedge clk27);
        #2;
        po_reset_n = 1'b0;
        #1;
        exp_state(nm, 16'h0000, 0, 1'b0);
        @(posedge clk27);
        #1;
        keycode_vld = 1'b0;
        po_reset_n  = 1'b1;
        tick();
    endtask

    // Monitor: compare every queued expectation against the DUT outputs at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk27);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                cmp({e.name, ".head"},  {16'h0, head_out}, {16'h0, e.head});
                cmp({e.name, ".count"}, {28'h0, count},    {28'h0, e.cnt});
                cmp({e.name, ".empty"}, {31'h0, empty},    {31'h0, e.emp});
                cmp({e.name, ".ovf"},   {31'h0, overflow}, {31'h0, e.ovf});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] drain_exp [8];
        drain_exp = '{16'h0103, 16'h0104, 16'h0105, 16'h0106,
                      16'h0107, 16'h0108, 16'h00AA, 16'h0000};

        po_reset_n  = 1'b0;
        keycode_in  = '0;
        keycode_vld = 1'b0;
        pop_tgl     = 1'b0;
        ovf_clr     = 1'b0;
        repeat (3) tick();
        exp_state("reset", 16'h0000, 0, 1'b0);
        tick();
        po_reset_n = 1'b1;
        tick();

        // Basic ordering and pop latency.
        push(16'h0011);
        push(16'h0022);
        push(16'h0033);
        exp_state("t1_three", 16'h0011, 3, 1'b0);
        pop();
        exp_state("t1_pop", 16'h0022, 2, 1'b0);
        pop();
        pop();
        exp_state("t1_drain", 16'h0000, 0, 1'b0);

        // Overfill by one, then clear the sticky flag.
        for (int i = 1; i <= 9; i++) push(16'h0100 + 16'(i));
        exp_state("t2_full", 16'h0101, 8, 1'b1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        exp_state("t2_clr", 16'h0101, 8, 1'b0);

        // Full FIFO: push and pop together, then drain.
        keycode_in  = 16'h00AA;
        keycode_vld = 1'b1;
        pop_tgl     = ~pop_tgl;
        tick();
        keycode_vld = 1'b0;
        tick();
        exp_state("t3_swap", 16'h0102, 8, 1'b0);
        for (int i = 0; i < 8; i++) begin
            pop();
            exp_state($sformatf("t3_drain%0d", i), drain_exp[i], 7 - i, 1'b0);
        end

        // Pops of an empty FIFO are ignored.
        for (int i = 0; i < 3; i++) begin
            pop();
            exp_state($sformatf("t4_epop%0d", i), 16'h0000, 0, 1'b0);
        end
        push(16'h1234);
        exp_state("t4_push", 16'h1234, 1, 1'b0);
        pop();
        exp_state("t4_pop", 16'h0000, 0, 1'b0);

        // Push and pop together on an empty FIFO, then with one entry (head bypass).
        keycode_in  = 16'h0777;
        keycode_vld = 1'b1;
        pop_tgl     = ~pop_tgl;
        tick();
        keycode_vld = 1'b0;
        tick();
        exp_state("pp_empty", 16'h0777, 1, 1'b0);
        keycode_in  = 16'h0888;
        keycode_vld = 1'b1;
        pop_tgl     = ~pop_tgl;
        tick();
        exp_state("pp_one", 16'h0888, 1, 1'b0);
        keycode_vld = 1'b0;
        tick();
        pop();
        exp_state("pp_drain", 16'h0000, 0, 1'b0);

        // Overflow set and clear in the same cycle: set wins.
        for (int i = 1; i <= 8; i++) push(16'h0200 + 16'(i));
        exp_state("ovf_fill", 16'h0201, 8, 1'b0);
        keycode_in  = 16'h0209;
        keycode_vld = 1'b1;
        ovf_clr     = 1'b1;
        tick();
        keycode_vld = 1'b0;
        ovf_clr     = 1'b0;
        tick();
        exp_state("ovf_setwins", 16'h0201, 8, 1'b1);
        mid_reset("rst_full");

        // Held valid gives one push; reset mid-hold empties at once.
        keycode_in  = 16'h0055;
        keycode_vld = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 4) exp_state("t5_hold_mid", 16'h0055, 1, 1'b0);
        end
        exp_state("t5_hold_end", 16'h0055, 1, 1'b0);
        mid_reset("t5_reset");
        exp_state("t5_after", 16'h0000, 0, 1'b0);

        // Duplicate filtering.
        push(16'h0042);
        push(16'h0042);
        push(16'h0043);
`ifdef KEYCODE_DUP_FILTER_EN
        exp_state("t6_dup", 16'h0042, 2, 1'b0);
`else
        exp_state("t6_dup", 16'h0042, 3, 1'b0);
`endif

        repeat (3) tick();
        cmp("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
